// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: multi-cycle DIV/DIVU sequencer and HI/LO write arbiter
module hilo_div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              annul_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              ex_we_i,
    input  logic [DATA_W-1:0] ex_hi_i,
    input  logic [DATA_W-1:0] ex_lo_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              div_zero_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hilo_hi_o,
    output logic [DATA_W-1:0] hilo_lo_o
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic [DATA_W-1:0] abs1, abs2, res_hi, res_lo;
    logic [DATA_W:0]   diff;
    logic              accept, s1, s2;
    assign s1     = signed_i & opdata1_i[DATA_W-1];
    assign s2     = signed_i & opdata2_i[DATA_W-1];
    assign abs1   = s1 ? -opdata1_i : opdata1_i;
    assign abs2   = s2 ? -opdata2_i : opdata2_i;
    assign accept = start_i & ~annul_i;
    assign diff   = {rem_q, quot_q[DATA_W-1]} - {1'b0, dvs_q};
    assign res_hi = rneg_q ? -rem_q : rem_q;
    assign res_lo = qneg_q ? -quot_q : quot_q;
    // state and datapath registers; reset discards any pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
    // next state: operand capture, one restoring step per ON cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d = '0;
                dvs_d = abs2;
                if (opdata2_i == '0) begin
                    state_d = ZERO;
                    rem_d   = opdata1_i;
                    quot_d  = '1;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                end else begin
                    state_d = ON;
                    rem_d   = '0;
                    quot_d  = abs1;
                    qneg_d  = s1 ^ s2;
                    rneg_d  = s1;
                end
            end
            ON: if (annul_i) state_d = IDLE;
                else begin
                    rem_d   = diff[DATA_W] ? {rem_q[DATA_W-2:0], quot_q[DATA_W-1]} : diff[DATA_W-1:0];
                    quot_d  = {quot_q[DATA_W-2:0], ~diff[DATA_W]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(DATA_W - 1)) ? END : ON;
                end
            ZERO:    state_d = annul_i ? IDLE : END;
            default: state_d = IDLE;
        endcase
    end
    // outputs: divider owns HI/LO in END, EX passes through only in IDLE
    always_comb begin
        stall_o    = ~rst & ((state_q == IDLE & accept) | state_q == ON | state_q == ZERO);
        busy_o     = ~rst & (state_q != IDLE);
        div_zero_o = ~rst & (state_q == ZERO);
        hilo_we_o  = ~rst & ((state_q == END) | (state_q == IDLE & ex_we_i));
        hilo_hi_o  = rst ? '0 : (state_q == END) ? res_hi : (state_q == IDLE) ? ex_hi_i : '0;
        hilo_lo_o  = rst ? '0 : (state_q == END) ? res_lo : (state_q == IDLE) ? ex_lo_i : '0;
    end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: vector table, directed corner sequences and random divides vs arithmetic model
module tb_hilo_div_ctrl;
    logic        clk = 0, rst = 1;
    logic        start_i = 0, signed_i = 0, annul_i = 0, ex_we_i = 0;
    logic [31:0] opdata1_i = 0, opdata2_i = 0, ex_hi_i = 0, ex_lo_i = 0;
    logic        stall_o, busy_o, div_zero_o, hilo_we_o;
    logic [31:0] hilo_hi_o, hilo_lo_o;
    int          vectors = 0, miscompares = 0;

    hilo_div_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .ex_we_i(ex_we_i), .ex_hi_i(ex_hi_i),
        .ex_lo_i(ex_lo_i), .stall_o(stall_o), .busy_o(busy_o), .div_zero_o(div_zero_o),
        .hilo_we_o(hilo_we_o), .hilo_hi_o(hilo_hi_o), .hilo_lo_o(hilo_lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        bit          s;
        logic [31:0] hi, lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        if (b == 0) begin
            hi = a;
            lo = '1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic div_run(input logic [31:0] a, input logic [31:0] b, input bit s,
                           output int end_cyc, output int stalls, output int zcyc,
                           output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        start_i = 1; signed_i = s; opdata1_i = a; opdata2_i = b;
        #1;
        stalls = int'(stall_o); end_cyc = -1; zcyc = -1; hi = 0; lo = 0;
        for (int c = 1; c < 40 && end_cyc < 0; c++) begin
            @(negedge clk);
            start_i = 0;
            #1;
            if (stall_o) stalls++;
            if (div_zero_o) zcyc = c;
            if (hilo_we_o) begin end_cyc = c; hi = hilo_hi_o; lo = hilo_lo_o; end
        end
    endtask

    initial begin
        vec_t        tbl[$];
        int          ec, st, zc, we_cnt;
        logic [31:0] hi, lo, ehi, elo, a, b;
        bit          s, z;
        tbl.push_back('{32'd100,       32'd7,          1'b0, 32'd2,        32'd14});
        tbl.push_back('{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD});
        tbl.push_back('{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'd0,        32'h80000000});
        tbl.push_back('{32'h00001234,  32'd0,          1'b0, 32'h00001234, 32'hFFFFFFFF});
        tbl.push_back('{32'd7,         32'hFFFFFFFE,   1'b1, 32'd1,        32'hFFFFFFFD});
        tbl.push_back('{32'hFFFFFFF9,  32'd0,          1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF});
        tbl.push_back('{32'hFFFFFFFF,  32'd1,          1'b0, 32'd0,        32'hFFFFFFFF});
        tbl.push_back('{32'd5,         32'd9,          1'b0, 32'd5,        32'd0});

        // reset holds every output low even with EX/start requests present
        ex_we_i = 1; ex_hi_i = 32'hA; ex_lo_i = 32'hB; start_i = 1; opdata2_i = 3;
        #3;
        chk("rst_stall", {31'd0, stall_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_we", {31'd0, hilo_we_o}, 0);
        chk("rst_hi", hilo_hi_o, 0);
        chk("rst_lo", hilo_lo_o, 0);
        chk("rst_zero", {31'd0, div_zero_o}, 0);
        start_i = 0; ex_we_i = 0;
        @(negedge clk); rst = 0;

        // IDLE pass-through, same cycle
        @(negedge clk);
        ex_we_i = 1; ex_hi_i = 32'hA; ex_lo_i = 32'hB;
        #1;
        chk("pass_we", {31'd0, hilo_we_o}, 1);
        chk("pass_hi", hilo_hi_o, 32'hA);
        chk("pass_lo", hilo_lo_o, 32'hB);
        ex_we_i = 0;

        // table vectors
        foreach (tbl[i]) begin
            z = (tbl[i].b == 0);
            div_run(tbl[i].a, tbl[i].b, tbl[i].s, ec, st, zc, hi, lo);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
            chk($sformatf("tbl%0d_endcyc", i), ec, z ? 2 : 33);
            chk($sformatf("tbl%0d_stalls", i), st, z ? 2 : 33);
            chk($sformatf("tbl%0d_zcyc", i), zc, z ? 1 : -1);
            @(negedge clk); #1;
            chk($sformatf("tbl%0d_busy_after", i), {31'd0, busy_o}, 0);
        end

        // EX write blocked during ON, divider wins in END, start ignored in END
        @(negedge clk);
        start_i = 1; signed_i = 0; opdata1_i = 100; opdata2_i = 7;
        ex_we_i = 1; ex_hi_i = 32'h55; ex_lo_i = 32'h66;
        #1;
        chk("blk_c0_we", {31'd0, hilo_we_o}, 1);
        we_cnt = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk); start_i = 0; #1;
            if (hilo_we_o) we_cnt++;
        end
        chk("blk_on_we_cnt", we_cnt, 0);
        @(negedge clk);
        start_i = 1; opdata1_i = 50; opdata2_i = 5;
        #1;
        chk("blk_end_we", {31'd0, hilo_we_o}, 1);
        chk("blk_end_hi", hilo_hi_o, 2);
        chk("blk_end_lo", hilo_lo_o, 14);
        chk("blk_end_stall", {31'd0, stall_o}, 0);
        @(negedge clk); start_i = 0; ex_we_i = 0; #1;
        chk("blk_no_restart", {31'd0, busy_o}, 0);

        // start with annul is ignored
        @(negedge clk);
        start_i = 1; annul_i = 1; opdata1_i = 9; opdata2_i = 3;
        #1;
        chk("sa_stall", {31'd0, stall_o}, 0);
        @(negedge clk); start_i = 0; annul_i = 0; #1;
        chk("sa_busy", {31'd0, busy_o}, 0);

        // annul at cycle 10 of a divide
        @(negedge clk);
        start_i = 1; opdata1_i = 1000; opdata2_i = 3;
        we_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start_i = 0;
            annul_i = (c == 10);
            #1;
            if (hilo_we_o) we_cnt++;
            if (c == 11) begin
                chk("annul_stall", {31'd0, stall_o}, 0);
                chk("annul_busy", {31'd0, busy_o}, 0);
            end
        end
        annul_i = 0;
        chk("annul_we_cnt", we_cnt, 0);

        // asynchronous reset mid-divide, then a fresh divide
        @(negedge clk);
        start_i = 1; opdata1_i = 1000; opdata2_i = 3; ex_we_i = 1;
        for (int c = 1; c < 20; c++) begin @(negedge clk); start_i = 0; end
        #1 rst = 1;
        #1;
        chk("mrst_stall", {31'd0, stall_o}, 0);
        chk("mrst_busy", {31'd0, busy_o}, 0);
        chk("mrst_we", {31'd0, hilo_we_o}, 0);
        chk("mrst_hi", hilo_hi_o, 0);
        @(negedge clk); rst = 0; ex_we_i = 0;
        div_run(32'd9, 32'd3, 1'b0, ec, st, zc, hi, lo);
        chk("mrst_div_hi", hi, 0);
        chk("mrst_div_lo", lo, 3);
        chk("mrst_div_endcyc", ec, 33);

        // randomized divides against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000)));
            if ($urandom_range(0, 1)) b = -b;
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, ehi, elo);
            div_run(a, b, s, ec, st, zc, hi, lo);
            chk($sformatf("rnd%0d_hi", i), hi, ehi);
            chk($sformatf("rnd%0d_lo", i), lo, elo);
            chk($sformatf("rnd%0d_endcyc", i), ec, (b == 0) ? 2 : 33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
